alu_mdu: RTL
============

ALU_MDU -- requirements
Module: alu_mdu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand and result width in bits; legal values are even and >= 8.
REQ-002 SHALL have parameter CNT_W, default $clog2(WIDTH)+1, giving the iteration counter width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: a request is present.
REQ-006 SHALL have port in_ready, output, 1 bit: the unit accepts a request.
REQ-007 SHALL have port op, input, 3 bits: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-008 SHALL have ports src_a and src_b, input, WIDTH bits each: dividend/multiplicand and divisor/multiplier.
REQ-009 SHALL have port flush, input, 1 bit: abort the operation in flight.
REQ-010 SHALL have port out_valid, output, 1 bit: result is present.
REQ-011 SHALL have port out_ready, input, 1 bit: consumer takes the result.
REQ-012 SHALL have port result, output, WIDTH bits: operation result.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY, DONE; in_ready is 1 only in IDLE and out_valid is 1 only in DONE.
REQ-014 SHALL accept a request on a cycle with in_valid && in_ready && !flush, latching op and operands, and move to BUSY.
REQ-015 SHALL compute products by iterative shift-add of the absolute-value operands, one multiplier bit per cycle, over exactly WIDTH BUSY cycles, forming a 2*WIDTH product with sign correction according to op.
REQ-016 SHALL return the low WIDTH bits for MUL and the high WIDTH bits for MULH (signed x signed), MULHSU (signed src_a x unsigned src_b) and MULHU (unsigned x unsigned).
REQ-017 SHALL compute quotient and remainder by restoring division over exactly WIDTH BUSY cycles; the quotient truncates toward zero and the remainder takes the sign of the dividend.
REQ-018 SHALL complete divide by zero with one BUSY cycle: quotient all ones, remainder = src_a.
REQ-019 SHALL complete signed overflow (DIV or REM with src_a = 2^(WIDTH-1) and src_b = all ones) with one BUSY cycle: quotient = src_a, remainder = 0.
REQ-020 SHALL therefore give latency from the accept edge to out_valid=1 of WIDTH+1 cycles for normal operations and 2 cycles for the REQ-018 and REQ-019 special cases.
REQ-021 SHALL hold result and out_valid stable in DONE until out_ready=1, then go to IDLE on that edge.
REQ-022 SHALL, on flush=1 in any state, go to IDLE on the next edge, discard the result and accept nothing that cycle; flush overrides every other event.
REQ-023 SHALL not accept a request in the same cycle that a result is delivered; the minimum request spacing is latency+1 cycles.

Reset
REQ-024 SHALL, while rst=1, force state IDLE, in_ready=1, out_valid=0, result=0, and clear the counter and datapath registers, independent of clk.
REQ-025 SHALL discard any in-flight operation when rst is asserted mid-operation, with no out_valid after release.

Configuration
REQ-026 SHALL compile the division datapath (ops 4-7) only when the macro LX32_MDU_DIV_EN is defined.
REQ-027 SHALL, without LX32_MDU_DIV_EN, complete ops 4-7 after one BUSY cycle with result=0, leaving the multiply behaviour and timing unchanged.

Verification
REQ-028 SHALL be verified (WIDTH=32) by: MUL 0x00000007 x 0xFFFFFFFD -> result 0xFFFFFFEB, out_valid 33 cycles after accept.
REQ-029 SHALL be verified by: MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH of the same operands -> 0x00000000; MULHSU 0xFFFFFFFF x 0x00000002 -> 0xFFFFFFFF.
REQ-030 SHALL be verified by: DIV -7 / 2 -> 0xFFFFFFFD; REM -7 / 2 -> 0xFFFFFFFF; DIVU 100 / 0 -> 0xFFFFFFFF; REMU 100 / 0 -> 100, the latter two in 2 cycles.
REQ-031 SHALL be verified by: DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0, each in 2 cycles.
REQ-032 SHALL be verified by: out_ready held 0 for 5 cycles in DONE -> result stable and in_ready=0, then delivered on the first out_ready=1 edge.
REQ-033 SHALL be verified by: flush at BUSY cycle 10 -> IDLE next edge with no out_valid; rst asserted at BUSY cycle 5 -> outputs at their reset values immediately.

Source files
------------

// File: rtl/alu_mdu.sv
// alu_mdu: iterative RISC-V M-extension multiply/divide unit.
// Multiply uses shift-add, one multiplier bit per cycle, over WIDTH cycles.
// Divide uses restoring division over WIDTH cycles.
// Divide by zero and signed overflow finish after a single BUSY cycle.
//
// Divide datapath (ops 4-7) is built only with macro LX32_MDU_DIV_EN.
// Without the macro, ops 4-7 finish after one BUSY cycle with result 0.
//
// Ports:
//   clk, rst            clock, async active-high reset
//   in_valid, in_ready  request handshake
//   op, src_a, src_b    operation and operands
//   flush               abort whatever is in flight
//   out_valid, out_ready, result  result handshake and value
module alu_mdu #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result
);

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [2:0]         op_q;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] acc;
    logic [CNT_W-1:0]   cnt;
    logic               neg_lo;
    logic               neg_hi;
    logic               special;
    logic [WIDTH-1:0]   spec_res;
    logic [WIDTH-1:0]   result_q;

    logic accept;
    logic last;

    // Request decode
    logic             a_sgn;
    logic             b_sgn;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic             is_div;
    logic             sp_in;
    logic [WIDTH-1:0] sp_res_in;

    // Iteration step
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_nxt;
    logic [2*WIDTH-1:0] div_nxt;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   fin;

    assign accept = (state == IDLE) && in_valid && !flush;
    assign is_div = op[2];

    always_comb begin
        a_sgn = (op == OP_MULH) || (op == OP_MULHSU) ||
                (op == OP_DIV)  || (op == OP_REM);
        b_sgn = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
        a_neg = a_sgn && src_a[WIDTH-1];
        b_neg = b_sgn && src_b[WIDTH-1];
        a_abs = a_neg ? (WIDTH'(0) - src_a) : src_a;
        b_abs = b_neg ? (WIDTH'(0) - src_b) : src_b;
    end

`ifdef LX32_MDU_DIV_EN
    logic div_zero;
    logic div_ovf;

    always_comb begin
        div_zero = (src_b == '0);
        div_ovf  = ((op == OP_DIV) || (op == OP_REM)) &&
                   (src_a == {1'b1, {(WIDTH-1){1'b0}}}) &&
                   (src_b == '1);
        sp_in     = is_div && (div_zero || div_ovf);
        sp_res_in = '0;
        if (div_zero) begin
            sp_res_in = ((op == OP_DIV) || (op == OP_DIVU)) ? '1 : src_a;
        end else if (div_ovf) begin
            sp_res_in = (op == OP_DIV) ? src_a : '0;
        end
    end

    // Restoring step: shift {rem, quo} left, try to subtract the divisor
    // from the widened partial remainder, keep the difference if it fits.
    logic [WIDTH+1:0] trial;

    always_comb begin
        trial = {1'b0, acc[2*WIDTH-1:WIDTH-1]} - {2'b00, mcand};
        if (!trial[WIDTH+1]) begin
            div_nxt = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end else begin
            div_nxt = {acc[2*WIDTH-2:0], 1'b0};
        end
    end
`else
    always_comb begin
        sp_in     = is_div;
        sp_res_in = '0;
        div_nxt   = acc;
    end
`endif

    // Shift-add step: low half holds the remaining multiplier bits.
    always_comb begin
        mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} +
                  {1'b0, (acc[0] ? mcand : WIDTH'(0))};
        mul_nxt = {mul_sum, acc[WIDTH-1:1]};
        acc_nxt = op_q[2] ? div_nxt : mul_nxt;
    end

    // Sign correction of the finished magnitude result.
    always_comb begin
        prod = neg_lo ? ((2*WIDTH)'(0) - acc_nxt) : acc_nxt;
        fin  = '0;
        unique case (op_q)
            OP_MUL:  fin = prod[WIDTH-1:0];
            3'd1, 3'd2, 3'd3: fin = prod[2*WIDTH-1:WIDTH];
            OP_DIV, OP_DIVU: begin
                fin = neg_lo ? (WIDTH'(0) - acc_nxt[WIDTH-1:0])
                             : acc_nxt[WIDTH-1:0];
            end
            default: begin
                fin = neg_hi ? (WIDTH'(0) - acc_nxt[2*WIDTH-1:WIDTH])
                             : acc_nxt[2*WIDTH-1:WIDTH];
            end
        endcase
    end

    assign last = special || (cnt == CNT_W'(WIDTH - 1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; flush wins over everything else
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE: if (in_valid) state_nxt = BUSY;
                BUSY: if (last) state_nxt = DONE;
                DONE: if (out_ready) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Output logic
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        result    = result_q;
    end

    // Datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q     <= '0;
            mcand    <= '0;
            acc      <= '0;
            cnt      <= '0;
            neg_lo   <= 1'b0;
            neg_hi   <= 1'b0;
            special  <= 1'b0;
            spec_res <= '0;
            result_q <= '0;
        end else if (accept) begin
            op_q     <= op;
            cnt      <= '0;
            special  <= sp_in;
            spec_res <= sp_res_in;
            neg_lo   <= a_neg ^ b_neg;
            neg_hi   <= is_div ? a_neg : (a_neg ^ b_neg);
            if (is_div) begin
                mcand <= b_abs;
                acc   <= {{WIDTH{1'b0}}, a_abs};
            end else begin
                mcand <= a_abs;
                acc   <= {{WIDTH{1'b0}}, b_abs};
            end
        end else if (state == BUSY && !flush) begin
            cnt <= cnt + 1'b1;
            acc <= acc_nxt;
            if (last) begin
                result_q <= special ? spec_res : fin;
            end
        end
    end

endmodule
